uart_rx_engine: RTL

- Serial receive engine sitting directly upstream of the uart MMIO register block.
- Oversamples the asynchronous `rx` pin against the programmed clock divider, deframes start/data/parity/stop bits and holds the received byte for the register block.
- The register block copies `rx_data` into DI, derives RXR from `rx_full` and pulses `rx_ack` when DI is read.

---
 rtl/uart_rx_engine.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx_engine.sv
// UART receive engine: synchronizes and oversamples rx, deframes start/data/parity/stop,
// and holds the received byte plus sticky error flags for the register block.
module uart_rx_engine #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_en,
  input  logic [15:0] cdiv,
  input  logic [1:0] parity_mode,
  input  logic       rx,
  input  logic       rx_ack,
  input  logic       err_clr,
  output logic [7:0] rx_data,
  output logic       rx_full,
  output logic       rx_busy,
  output logic       ferr,
  output logic       perr,
  output logic       ovr
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [SYNC_STAGES-1:0] sync_q, sync_vld_q;
  logic        rx_s, rx_prev_q, armed_q, armed_d, fall;
  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d, pmax_q, pmax_d, half_m1;
  logic [2:0]  bitn_q, bitn_d;
  logic [7:0]  shift_q, shift_d, rx_data_q, rx_data_d;
  logic        dlv_q, dlv_d, rx_full_q, rx_full_d;
  logic        ferr_q, ferr_d, perr_q, perr_d, ovr_q, ovr_d;
  logic        ferr_set, perr_set, ovr_set, par_on, par_exp;

  assign rx_s = sync_q[SYNC_STAGES-1];
  // After reset the synchronizer holds 1s that never came from the line, so a start
  // edge is only trusted once a genuine high level has propagated through.
  assign armed_d = armed_q | (&sync_vld_q & rx_s);
  assign fall    = armed_q & rx_prev_q & ~rx_s;

  assign half_m1 = ({1'b0, pmax_q[15:1]} + {15'd0, pmax_q[0]}) - 16'd1;
  assign par_on  = ^parity_mode;
  assign par_exp = parity_mode[1] ? ~^shift_q : ^shift_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 16'd1;
    bitn_d   = bitn_q;
    shift_d  = shift_q;
    pmax_d   = pmax_q;
    dlv_d    = 1'b0;
    ferr_set = 1'b0;
    perr_set = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        bitn_d = '0;
        if (fall) begin
          state_d = START;
          pmax_d  = (cdiv < 16'd3) ? 16'd3 : cdiv;
        end
      end
      START: if (cnt_q == half_m1) begin
        cnt_d   = '0;
        state_d = rx_s ? IDLE : DATA;
      end
      DATA: if (cnt_q == pmax_q) begin
        cnt_d   = '0;
        shift_d = {rx_s, shift_q[7:1]};
        bitn_d  = bitn_q + 3'd1;
        if (bitn_q == 3'd7) state_d = par_on ? PARITY : STOP;
      end
      PARITY: if (cnt_q == pmax_q) begin
        cnt_d    = '0;
        perr_set = (rx_s != par_exp);
        state_d  = STOP;
      end
      STOP: if (cnt_q == pmax_q) begin
        cnt_d    = '0;
        state_d  = IDLE;
        dlv_d    = rx_s;
        ferr_set = ~rx_s;
      end
      default: state_d = IDLE;
    endcase
    if (!rx_en) begin
      state_d  = IDLE;
      dlv_d    = 1'b0;
      ferr_set = 1'b0;
      perr_set = 1'b0;
    end
  end

  // Delivery happens one cycle after the stop sample so rx_ack in that cycle can race it.
  always_comb begin
    rx_data_d = rx_data_q;
    rx_full_d = rx_full_q;
    ovr_set   = 1'b0;
    if (dlv_q) begin
      if (!rx_full_q || rx_ack) begin
        rx_data_d = shift_q;
        rx_full_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (rx_ack) begin
      rx_full_d = 1'b0;
    end
    ferr_d = (ferr_q & ~err_clr) | ferr_set;
    perr_d = (perr_q & ~err_clr) | perr_set;
    ovr_d  = (ovr_q  & ~err_clr) | ovr_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '1;
      sync_vld_q <= '0;
      rx_prev_q  <= 1'b1;
      armed_q    <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      pmax_q     <= 16'd3;
      bitn_q     <= '0;
      shift_q    <= '0;
      dlv_q      <= 1'b0;
      rx_data_q  <= '0;
      rx_full_q  <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], rx};
      sync_vld_q <= {sync_vld_q[SYNC_STAGES-2:0], 1'b1};
      rx_prev_q  <= rx_s;
      armed_q    <= armed_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pmax_q     <= pmax_d;
      bitn_q     <= bitn_d;
      shift_q    <= shift_d;
      dlv_q      <= dlv_d;
      rx_data_q  <= rx_data_d;
      rx_full_q  <= rx_full_d;
      ferr_q     <= ferr_d;
      perr_q     <= perr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rx_data = rx_data_q;
  assign rx_full = rx_full_q;
  assign rx_busy = (state_q != IDLE);
  assign ferr    = ferr_q;
  assign perr    = perr_q;
  assign ovr     = ovr_q;

endmodule
